alu_control_fsm: RTL
====================

Name: alu_control_fsm

Overview:
- Multi-cycle instruction sequencer for the 16-bit datapath.
- Fetches an instruction word, decodes it, and drives the ALU function-select (FS), carry-in, and register-file controls.
- Captures the ALU status flags {V,C,N,Z} into a flags register and resolves conditional branches from those flags.
- It is the producer of FS/Cin and the consumer of status/Cout; the ALU is purely combinational between them.

Parameters:
- N, 16, datapath width (for flag/width consistency only; no data passes through this block).
- PC_W, 16, program counter width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- instr_req  output  1  fetch request, high only in FETCH
- instr_addr  output  PC_W  fetch address, equals PC
- instr_valid  input  1  instr is valid this cycle
- instr  input  16  instruction word
- FS  output  5  ALU function select
- Cin  output  1  ALU carry-in
- alu_status  input  4  ALU {V,C,N,Z}
- alu_cout  input  1  ALU carry-out
- rd_addr, ra_addr, rb_addr  output  3 each  register-file destination and sources
- rf_we  output  1  register-file write enable, one-cycle pulse
- flags  output  4  registered {V,C,N,Z}
- halted  output  1  sticky, set by HALT
- illegal  output  1  sticky, set by an undefined opcode

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Instruction format:
  - op = instr[15:11], rd = [10:8], ra = [7:5], rb = [4:2], off = [7:0] (signed, branches only).
- Opcode map:
  - 0x00–0x10: ALU ops; FS = op (0 CLR, 1 ADD, 2 SUB, 3 DEC, 4 NEG, 5 XOR, 6 ADDC, 7 INC, 8 SET, 9 NOT, 10 AND, 11 OR, 12 MOVA, 13 SHR, 14 SHL, 15 ASHR, 16 MOVB).
  - 0x11 BZ, 0x12 BN, 0x13 BC, 0x14 JMP (unconditional).
  - 0x1F HALT.
  - All other opcodes are illegal.
- States: RST_IDLE, FETCH, DECODE, EXEC, WB, BRANCH, HALT, ILLEGAL.
- Reset (async assert):
  - state = RST_IDLE, PC = RESET_PC, IR = 0, flags = 0, FS = 0, Cin = 0.
  - rd/ra/rb = 0, rf_we = 0, instr_req = 0, halted = 0, illegal = 0.
  - Reset mid-instruction aborts immediately; no partial writeback and no flag update.
- Transitions:
  - RST_IDLE -> FETCH on the first clock after reset deasserts.
  - FETCH: instr_req = 1. Stays in FETCH while instr_valid = 0, for any number of cycles. On instr_valid = 1, latch IR and go to DECODE.
  - DECODE:
    - ALU op -> EXEC.
    - 0x11–0x14 -> BRANCH.
    - 0x1F -> HALT.
    - Otherwise -> ILLEGAL.
  - EXEC: FS, ra_addr, rb_addr, rd_addr driven from registers loaded in DECODE. Cin = flags.C when op == 6 (ADDC), else 0. -> WB.
  - WB:
    - rf_we = 1 for exactly this cycle.
    - flags <= {alu_status[3], alu_cout, alu_status[1:0]}, so C comes from alu_cout.
    - PC <= PC+1. -> FETCH.
  - BRANCH:
    - Taken (BZ with Z = 1, BN with N = 1, BC with C = 1, or JMP): PC <= PC + 1 + sign_extend(off).
    - Not taken: PC <= PC + 1.
    - flags unchanged, rf_we = 0. -> FETCH.
  - HALT, ILLEGAL: terminal until reset. Set the respective sticky output. instr_req = 0, rf_we = 0, PC frozen.
- FS and Cin hold their last values outside EXEC/WB; they return to 0 only on reset.
- All PC arithmetic is modulo 2^PC_W:
  - 0xFFFF+1 = 0x0000.
  - Backward branch below 0 wraps.
- Latency: ALU instruction = 4 cycles (FETCH, DECODE, EXEC, WB) with zero fetch wait. Branch = 3 cycles.
- instr is ignored outside FETCH. instr_valid while instr_req = 0 has no effect.
- Only ALU ops update flags. CLR/SET/MOV update all four flags from ALU status like any other ALU op.

Test Plan:
- Reset, then ADD r3,r1,r2 (instr 0x0B28) with instr_valid immediate; bench ALU status = 4'b0000, cout = 0 -> FS = 1 in EXEC, rd = 3/ra = 1/rb = 2, rf_we pulses once in cycle 4, PC = 1, flags = 0.
- ADD with alu_cout = 1, then ADDC -> Cin = 1 during the ADDC EXEC. Then ADD with cout = 0, then ADDC -> Cin = 0.
- Set Z = 1 via CLR, then BZ off = 0xFE at PC = 5 -> PC = 4. BZ with Z = 0 -> PC = 6. BC when C = 0 -> not taken.
- PC = 0xFFFF executing INC -> PC wraps to 0x0000. JMP off = 0x80 at PC = 0x0010 -> PC = 0xFF91.
- Opcode 0x18 -> illegal = 1, instr_req stays 0 for 20 cycles. Opcode 0x1F -> halted = 1. Both clear only after reset.
- Hold instr_valid = 0 for 7 cycles in FETCH -> no state change, instr_req held high. Assert reset low during EXEC of SUB -> rf_we never pulses, flags = 0, PC = RESET_PC.

Source files
------------

// File: rtl/alu_control_fsm.sv
// alu_control_fsm: multi-cycle instruction sequencer for the 16-bit datapath.
// Fetches a 16-bit instruction, decodes it and drives the combinational ALU's
// function select and carry-in plus the register-file address/write controls.
// The ALU's {V,C,N,Z} result is captured into a flags register on writeback,
// and conditional branches resolve against those registered flags.
module alu_control_fsm #(
  parameter int              N        = 16,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,        // asynchronous, active-low
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic [4:0]      FS,
  output logic            Cin,
  input  logic [3:0]      alu_status,   // {V,C,N,Z}
  input  logic            alu_cout,
  output logic [2:0]      rd_addr,
  output logic [2:0]      ra_addr,
  output logic [2:0]      rb_addr,
  output logic            rf_we,
  output logic [3:0]      flags,        // {V,C,N,Z}
  output logic            halted,
  output logic            illegal
);

  // Bit positions inside a {V,C,N,Z} nibble.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Opcode map: 0x00..0x10 are ALU ops whose opcode is also the FS code.
  localparam logic [4:0] OP_ALU_LAST = 5'h10;
  localparam logic [4:0] OP_ADDC     = 5'h06;
  localparam logic [4:0] OP_BZ       = 5'h11;
  localparam logic [4:0] OP_BN       = 5'h12;
  localparam logic [4:0] OP_BC       = 5'h13;
  localparam logic [4:0] OP_JMP      = 5'h14;
  localparam logic [4:0] OP_HALT     = 5'h1F;

  typedef enum logic [2:0] {
    S_RST_IDLE = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_WB       = 3'd4,
    S_BRANCH   = 3'd5,
    S_HALT     = 3'd6,
    S_ILLEGAL  = 3'd7
  } state_e;

  // Instruction fields as they sit in the instruction register.
  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [1:0] pad;
  } instr_t;

  state_e          state_q, state_d;
  instr_t          ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      flags_q, flags_d;
  logic [4:0]      fs_q, fs_d;
  logic            cin_q, cin_d;
  logic [2:0]      rd_q, rd_d;
  logic [2:0]      ra_q, ra_d;
  logic [2:0]      rb_q, rb_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

  // Decode helpers derived from the instruction register.
  logic            is_alu;
  logic            is_branch;
  logic            is_halt;
  logic            branch_taken;
  logic [7:0]      br_off;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_target;

  // The ALU's own C status bit is superseded by alu_cout, and N only documents
  // the datapath width; both are intentionally left unconsumed.
  logic unused_ok;
  assign unused_ok = ^{alu_status[FLAG_C], N[0]};

  assign is_alu    = (ir_q.op <= OP_ALU_LAST);
  assign is_branch = (ir_q.op >= OP_BZ) && (ir_q.op <= OP_JMP);
  assign is_halt   = (ir_q.op == OP_HALT);

  // Branch offset overlays ra/rb/pad; it is a signed 8-bit word offset.
  assign br_off    = {ir_q.ra, ir_q.rb, ir_q.pad};
  assign off_ext   = {{(PC_W-8){br_off[7]}}, br_off};
  // PC arithmetic simply wraps modulo 2^PC_W in both directions.
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_target = pc_inc + off_ext;

  // Resolve the branch condition against the registered flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    branch_taken = 1'b0;
    case (ir_q.op)
      OP_BZ:   branch_taken = flags_q[FLAG_Z];
      OP_BN:   branch_taken = flags_q[FLAG_N];
      OP_BC:   branch_taken = flags_q[FLAG_C];
      OP_JMP:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  // State register; reset aborts any in-flight instruction immediately.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= S_RST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the fetch/decode/execute sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_alu) begin
          state_d = S_EXEC;
        end else if (is_branch) begin
          state_d = S_BRANCH;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_EXEC:    state_d = S_WB;
      S_WB:      state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_RST_IDLE;
    endcase
  end

  // Moore outputs: fetch request only in FETCH, write strobe only in WB.
  always_comb begin
    instr_req = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      S_FETCH: instr_req = 1'b1;
      S_WB:    rf_we     = 1'b1;
      default: begin
        instr_req = 1'b0;
        rf_we     = 1'b0;
      end
    endcase
  end

  // Datapath next values: IR capture, ALU control load, flag/PC updates.
  always_comb begin
    ir_d      = ir_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    fs_d      = fs_q;
    cin_d     = cin_q;
    rd_d      = rd_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d = instr_t'(instr);
        end
      end
      S_DECODE: begin
        // ALU controls are loaded here so they are stable for all of EXEC and
        // WB; non-ALU instructions leave the previous controls untouched.
        if (is_alu) begin
          fs_d  = ir_q.op;
          cin_d = (ir_q.op == OP_ADDC) && flags_q[FLAG_C];
          rd_d  = ir_q.rd;
          ra_d  = ir_q.ra;
          rb_d  = ir_q.rb;
        end else if (is_halt) begin
          halted_d = 1'b1;
        end else if (!is_branch) begin
          illegal_d = 1'b1;
        end
      end
      S_WB: begin
        // Carry is taken from the ALU carry-out, not its status nibble.
        flags_d = {alu_status[FLAG_V], alu_cout, alu_status[FLAG_N], alu_status[FLAG_Z]};
        pc_d    = pc_inc;
      end
      S_BRANCH: begin
        pc_d = branch_taken ? pc_target : pc_inc;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Datapath registers; everything returns to its reset value asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q      <= '0;
      pc_q      <= RESET_PC;
      flags_q   <= '0;
      fs_q      <= '0;
      cin_q     <= 1'b0;
      rd_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      fs_q      <= fs_d;
      cin_q     <= cin_d;
      rd_q      <= rd_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_addr = pc_q;
  assign FS         = fs_q;
  assign Cin        = cin_q;
  assign rd_addr    = rd_q;
  assign ra_addr    = ra_q;
  assign rb_addr    = rb_q;
  assign flags      = flags_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule
